// File: rtl/rgb_process.sv
// rgb_process: two-stage pixel pipeline applying mode transform, brightness,
// channel masks and window blanking. Define RGB_PROCESS_BORDER_EN for a white frame border.
module rgb_process #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BRIGHT_STEP = 64,
  parameter int THRESH      = 128
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  input  logic        Icontrol1,
  input  logic        Icontrol2,
  input  logic        rIenable,
  input  logic        gIenable,
  input  logic        bIenable,
  input  logic        brightLevel,
  input  logic [7:0]  raw_VGA_R,
  input  logic [7:0]  raw_VGA_G,
  input  logic [7:0]  raw_VGA_B,
  input  logic [12:0] row,
  input  logic [12:0] col,
  output logic [7:0]  o_VGA_R,
  output logic [7:0]  o_VGA_G,
  output logic [7:0]  o_VGA_B
);

  typedef enum logic [1:0] {
    MODE_PASS   = 2'b00,
    MODE_GRAY   = 2'b01,
    MODE_INV    = 2'b10,
    MODE_THRESH = 2'b11
  } mode_t;

  localparam logic [12:0] H_LIM = 13'(H_ACTIVE);
  localparam logic [12:0] V_LIM = 13'(V_ACTIVE);
  localparam logic [8:0]  STEP  = 9'(BRIGHT_STEP);
  localparam logic [7:0]  THR   = 8'(THRESH);

  logic [15:0] luma_sum;
  logic [7:0]  luma;
  logic        in_window;

  logic [7:0]  s1_r, s1_g, s1_b, s1_y;
  mode_t       s1_mode;
  logic [2:0]  s1_mask;
  logic        s1_bright;
  logic        s1_in_window;

  logic [7:0]  mode_r, mode_g, mode_b;
  logic [7:0]  bright_r, bright_g, bright_b;
  logic [7:0]  nxt_r, nxt_g, nxt_b;

  // Weights sum to 256, so the shifted result never exceeds 255.
  assign luma_sum = 16'd77  * {8'd0, raw_VGA_R}
                  + 16'd150 * {8'd0, raw_VGA_G}
                  + 16'd29  * {8'd0, raw_VGA_B};
  assign luma      = 8'(luma_sum >> 8);
  assign in_window = (col < H_LIM) && (row < V_LIM);

`ifdef RGB_PROCESS_BORDER_EN
  logic on_border;
  logic s1_border;

  assign on_border = (row == 13'd0) || (row == V_LIM - 13'd1) ||
                     (col == 13'd0) || (col == H_LIM - 13'd1);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) s1_border <= 1'b0;
    else          s1_border <= on_border;
  end
`endif

  function automatic logic [7:0] brighten(input logic [7:0] c);
    logic [8:0] sum;
    sum = {1'b0, c} + STEP;
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

  // Controls are captured alongside the pixel so a change never splits a pixel.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_r         <= 8'd0;
      s1_g         <= 8'd0;
      s1_b         <= 8'd0;
      s1_y         <= 8'd0;
      s1_mode      <= MODE_PASS;
      s1_mask      <= 3'b000;
      s1_bright    <= 1'b0;
      s1_in_window <= 1'b0;
    end else begin
      s1_r         <= raw_VGA_R;
      s1_g         <= raw_VGA_G;
      s1_b         <= raw_VGA_B;
      s1_y         <= luma;
      s1_mode      <= mode_t'({Icontrol2, Icontrol1});
      s1_mask      <= {rIenable, gIenable, bIenable};
      s1_bright    <= brightLevel;
      s1_in_window <= in_window;
    end
  end

  always_comb begin
    mode_r = s1_r;
    mode_g = s1_g;
    mode_b = s1_b;
    case (s1_mode)
      MODE_GRAY: begin
        mode_r = s1_y;
        mode_g = s1_y;
        mode_b = s1_y;
      end
      MODE_INV: begin
        mode_r = ~s1_r;
        mode_g = ~s1_g;
        mode_b = ~s1_b;
      end
      MODE_THRESH: begin
        mode_r = (s1_y >= THR) ? 8'hFF : 8'h00;
        mode_g = mode_r;
        mode_b = mode_r;
      end
      default: ;
    endcase

    bright_r = s1_bright ? brighten(mode_r) : mode_r;
    bright_g = s1_bright ? brighten(mode_g) : mode_g;
    bright_b = s1_bright ? brighten(mode_b) : mode_b;

    nxt_r = s1_mask[2] ? 8'h00 : bright_r;
    nxt_g = s1_mask[1] ? 8'h00 : bright_g;
    nxt_b = s1_mask[0] ? 8'h00 : bright_b;

`ifdef RGB_PROCESS_BORDER_EN
    if (s1_border) begin
      nxt_r = 8'hFF;
      nxt_g = 8'hFF;
      nxt_b = 8'hFF;
    end
`endif

    // Blanking comes last so nothing can leak outside the active window.
    if (!s1_in_window) begin
      nxt_r = 8'h00;
      nxt_g = 8'h00;
      nxt_b = 8'h00;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      o_VGA_R <= 8'd0;
      o_VGA_G <= 8'd0;
      o_VGA_B <= 8'd0;
    end else begin
      o_VGA_R <= nxt_r;
      o_VGA_G <= nxt_g;
      o_VGA_B <= nxt_b;
    end
  end

endmodule

// File: tb/tb_rgb_process.sv
// tb_rgb_process: directed-vector bench for rgb_process with hand-computed expected pixels.
module tb_rgb_process;

  logic        CLOCK_50;
  logic        RESET_N;
  logic        Icontrol1, Icontrol2;
  logic        rIenable, gIenable, bIenable;
  logic        brightLevel;
  logic [7:0]  raw_VGA_R, raw_VGA_G, raw_VGA_B;
  logic [12:0] row, col;
  logic [7:0]  o_VGA_R, o_VGA_G, o_VGA_B;

  int total;
  int bad;

  rgb_process dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .Icontrol1  (Icontrol1),
    .Icontrol2  (Icontrol2),
    .rIenable   (rIenable),
    .gIenable   (gIenable),
    .bIenable   (bIenable),
    .brightLevel(brightLevel),
    .raw_VGA_R  (raw_VGA_R),
    .raw_VGA_G  (raw_VGA_G),
    .raw_VGA_B  (raw_VGA_B),
    .row        (row),
    .col        (col),
    .o_VGA_R    (o_VGA_R),
    .o_VGA_G    (o_VGA_G),
    .o_VGA_B    (o_VGA_B)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
    total++;
    assert ({o_VGA_R, o_VGA_G, o_VGA_B} === {er, eg, eb})
    else begin
      bad++;
      $error("[TB] FAIL %s: observed %0d/%0d/%0d expected %0d/%0d/%0d",
             tag, o_VGA_R, o_VGA_G, o_VGA_B, er, eg, eb);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [2:0] mask, input logic bright,
                               input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                               input logic [12:0] rw, input logic [12:0] cl);
    {Icontrol2, Icontrol1}           = mode;
    {rIenable, gIenable, bIenable}   = mask;
    brightLevel                      = bright;
    raw_VGA_R = r;
    raw_VGA_G = g;
    raw_VGA_B = b;
    row = rw;
    col = cl;
  endtask

  // Apply one pixel, hold it for two edges, then check the output.
  task automatic runPixel(input string tag, input logic [1:0] mode, input logic [2:0] mask,
                          input logic bright, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b, input logic [12:0] rw, input logic [12:0] cl,
                          input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb);
    applyStimulus(mode, mask, bright, r, g, b, rw, cl);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    checkOutput(tag, er, eg, eb);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RESET_N = 1'b0;
    applyStimulus(2'b00, 3'b000, 1'b0, 8'd0, 8'd0, 8'd0, 13'd0, 13'd0);
    #12;
    checkOutput("reset_state", 8'd0, 8'd0, 8'd0);

    // Release reset between edges with a pixel already waiting.
    applyStimulus(2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10);
    RESET_N = 1'b1;
    @(posedge CLOCK_50); #1;
    checkOutput("latency_edge1", 8'd0, 8'd0, 8'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("latency_edge2", 8'd200, 8'd100, 8'd50);

    runPixel("passthrough", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd200, 8'd100, 8'd50);
    runPixel("grayscale", 2'b01, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd124, 8'd124, 8'd124);
    runPixel("thresh_low", 2'b11, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd0, 8'd0, 8'd0);
    runPixel("thresh_high", 2'b11, 3'b000, 1'b0, 8'd255, 8'd255, 8'd255, 13'd10, 13'd10,
             8'd255, 8'd255, 8'd255);
    runPixel("invert", 2'b10, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd55, 8'd155, 8'd205);
    runPixel("bright", 2'b00, 3'b000, 1'b1, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd255, 8'd164, 8'd114);
    runPixel("bright_gmask", 2'b00, 3'b010, 1'b1, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd255, 8'd0, 8'd114);
    runPixel("rb_mask", 2'b00, 3'b101, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd0, 8'd100, 8'd0);
    runPixel("gray_bright", 2'b01, 3'b000, 1'b1, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd188, 8'd188, 8'd188);

    runPixel("blank_col640", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd640,
             8'd0, 8'd0, 8'd0);
    runPixel("blank_row480", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd480, 13'd10,
             8'd0, 8'd0, 8'd0);
    runPixel("blank_col_wrap", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'h1FFF,
             8'd0, 8'd0, 8'd0);
    runPixel("blank_inv_row_wrap", 2'b10, 3'b000, 1'b0, 8'd0, 8'd0, 8'd0, 13'h1FFF, 13'd10,
             8'd0, 8'd0, 8'd0);
`ifdef RGB_PROCESS_BORDER_EN
    runPixel("corner_639_479", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd479, 13'd639,
             8'd255, 8'd255, 8'd255);
`else
    runPixel("corner_639_479", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd479, 13'd639,
             8'd200, 8'd100, 8'd50);
`endif

    // Back-to-back stream, mode switching from passthrough to invert on the third pixel.
    applyStimulus(2'b00, 3'b000, 1'b0, 8'd10, 8'd20, 8'd30, 13'd20, 13'd20);
    @(posedge CLOCK_50); #1;
    applyStimulus(2'b00, 3'b000, 1'b0, 8'd40, 8'd50, 8'd60, 13'd20, 13'd21);
    @(posedge CLOCK_50); #1;
    checkOutput("stream_p0", 8'd10, 8'd20, 8'd30);
    applyStimulus(2'b10, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd20, 13'd22);
    @(posedge CLOCK_50); #1;
    checkOutput("stream_p1", 8'd40, 8'd50, 8'd60);
    applyStimulus(2'b10, 3'b000, 1'b0, 8'd0, 8'd1, 8'd255, 13'd20, 13'd23);
    @(posedge CLOCK_50); #1;
    checkOutput("stream_p2_inv", 8'd55, 8'd155, 8'd205);
    @(posedge CLOCK_50); #1;
    checkOutput("stream_p3_inv", 8'd255, 8'd254, 8'd0);

    // Asynchronous reset mid-stream, asserted between edges.
    runPixel("pre_reset", 2'b00, 3'b000, 1'b0, 8'd200, 8'd100, 8'd50, 13'd10, 13'd10,
             8'd200, 8'd100, 8'd50);
    #2;
    RESET_N = 1'b0;
    #1;
    checkOutput("async_reset", 8'd0, 8'd0, 8'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("reset_held", 8'd0, 8'd0, 8'd0);
    RESET_N = 1'b1;
    @(posedge CLOCK_50); #1;
    checkOutput("post_reset_edge1", 8'd0, 8'd0, 8'd0);
    @(posedge CLOCK_50); #1;
    checkOutput("post_reset_edge2", 8'd200, 8'd100, 8'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
